// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU front end: opcodes, arbiter FSM states
// and the opcode validity check.
package alu_pkg;

    localparam int OPW = 4;

    typedef enum logic [OPW-1:0] {
        SEL       = 4'h0,
        INC       = 4'h1,
        DEC       = 4'h2,
        ADD       = 4'h3,
        ADD_C     = 4'h4,
        SUB       = 4'h5,
        SUB_C     = 4'h6,
        AND       = 4'h7,
        OR        = 4'h8,
        XOR       = 4'h9,
        NOT       = 4'hA,
        SHIFT_L   = 4'hB,
        SHIFT_R   = 4'hC,
        ROTATE_R  = 4'hD,
        INVALID_1 = 4'hE,
        INVALID_2 = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        ERR
    } arb_state_e;

    function automatic logic is_valid_op(input logic [OPW-1:0] ctl);
        return !((ctl == INVALID_1) || (ctl == INVALID_2));
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant; the pointer remembers the last accepted requester
// so a tie goes to the other one.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
            else              gnt = req;
        end
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      last <= 1'b1;
        else if (accept) last <= gnt[1];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one registered 4-bit ALU between two requesters,
// with per-requester carry flags, invalid-opcode and timeout error responses.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int TIMEOUT = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [7:0]     req_a,
    input  logic [7:0]     req_b,
    input  logic [7:0]     req_ctl,
    input  logic [1:0]     flag_clr,
    output logic [1:0]     rsp_valid,
    output logic [OPW-1:0] rsp_result,
    output logic           rsp_carry,
    output logic           rsp_zero,
    output logic           rsp_err,
    output logic [1:0]     flag,
    output logic           alu_valid_in,
    output logic [OPW-1:0] alu_a,
    output logic [OPW-1:0] alu_b,
    output logic [OPW-1:0] alu_ctl,
    output logic           alu_cin,
    input  logic           alu_valid_out,
    input  logic [OPW-1:0] alu_result,
    input  logic           alu_carry,
    input  logic           alu_zero
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e     state, state_nxt;
    logic           owner;
    logic [1:0]     gnt;
    logic           hs;
    logic           sel;
    logic [OPW-1:0] sel_a, sel_b, sel_ctl;
    logic [CW-1:0]  cnt;
    logic [1:0]     owner_oh;
    logic [1:0]     flag_set;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .en     (state == IDLE),
        .req    (req_valid),
        .accept (hs),
        .gnt    (gnt)
    );

    assign req_ready = gnt;
    assign hs        = |gnt;
    assign sel       = gnt[1];
    assign sel_a     = sel ? req_a[7:4]   : req_a[3:0];
    assign sel_b     = sel ? req_b[7:4]   : req_b[3:0];
    assign sel_ctl   = sel ? req_ctl[7:4] : req_ctl[3:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = is_valid_op(sel_ctl) ? ISSUE : ERR;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (alu_valid_out)                 state_nxt = RESP;
                else if (cnt == CW'(TIMEOUT - 1))  state_nxt = ERR;
            end
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctl    <= '0;
            cnt        <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (hs) begin
                owner   <= sel;
                alu_a   <= sel_a;
                alu_b   <= sel_b;
                alu_ctl <= sel_ctl;
            end
            if (state == ISSUE)     cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 1'b1;
            if (state == WAIT && alu_valid_out) begin
                rsp_result <= alu_result;
                rsp_carry  <= alu_carry;
                rsp_zero   <= alu_zero;
                rsp_err    <= 1'b0;
            end
            // Only IDLE (bad opcode) and WAIT (timeout) can lead into ERR.
            if (state_nxt == ERR) rsp_err <= 1'b1;
        end
    end

    assign owner_oh = owner ? 2'b10 : 2'b01;
    assign flag_set = (state == RESP) ? owner_oh : 2'b00;

    // A clear on the same edge as a RESP update takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) flag <= 2'b00;
        else        flag <= ((flag & ~flag_set) | (flag_set & {2{rsp_carry}})) & ~flag_clr;
    end

    assign rsp_valid    = (state == RESP || state == ERR) ? owner_oh : 2'b00;
    assign alu_valid_in = (state == ISSUE);
    assign alu_cin      = flag[owner];

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written corner
// sequences and a randomized phase checked against a transaction-level model.
module tb_alu_arbiter;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [7:0] req_a = 8'h00, req_b = 8'h00, req_ctl = 8'h00;
    logic [1:0] flag_clr = 2'b00;
    logic [1:0] rsp_valid, flag;
    logic [3:0] rsp_result, alu_a, alu_b, alu_ctl;
    logic       rsp_carry, rsp_zero, rsp_err, alu_valid_in, alu_cin;
    logic       alu_valid_out;
    logic [3:0] alu_result;
    logic       alu_carry, alu_zero;
    logic       alu_stall = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctl(req_ctl),
        .flag_clr(flag_clr),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .flag(flag),
        .alu_valid_in(alu_valid_in), .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
        .alu_cin(alu_cin), .alu_valid_out(alu_valid_out), .alu_result(alu_result),
        .alu_carry(alu_carry), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // External ALU behaviour: returns {carry, result}
    function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] ctl, input logic cin);
        case (ctl)
            4'h0: return {1'b0, b};
            4'h1: return {1'b0, a} + 5'd1;
            4'h2: return {1'b0, a} - 5'd1;
            4'h3: return {1'b0, a} + {1'b0, b};
            4'h4: return {1'b0, a} + {1'b0, b} + {4'd0, cin};
            4'h5: return {1'b0, a} - {1'b0, b};
            4'h6: return {1'b0, a} - {1'b0, b} - {4'd0, cin};
            4'h7: return {1'b0, a & b};
            4'h8: return {1'b0, a | b};
            4'h9: return {1'b0, a ^ b};
            4'hA: return {1'b0, ~a};
            4'hB: return {a[3], a[2:0], 1'b0};
            4'hC: return {a[0], 1'b0, a[3:1]};
            4'hD: return {a[0], a[0], a[3:1]};
            default: return 5'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [4:0] r;
        r = alu_fn(alu_a, alu_b, alu_ctl, alu_cin);
        alu_valid_out <= alu_valid_in && !alu_stall;
        alu_result    <= r[3:0];
        alu_carry     <= r[4];
        alu_zero      <= (r[3:0] == 4'd0);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_ready"}, int'(req_ready), 0);
        chk({tag, "_rsp"}, int'({rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err}), 0);
        chk({tag, "_flag"}, int'(flag), 0);
        chk({tag, "_alu"}, int'({alu_valid_in, alu_a, alu_b, alu_ctl, alu_cin}), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        rst_checks("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Observations from one directed op, offsets counted from the accept cycle
    int         ob_iss, ob_rsp;
    logic [1:0] ob_rv, ob_flag;
    logic [3:0] ob_res, ob_a, ob_b, ob_ctl;
    logic       ob_c, ob_z, ob_e, ob_cin;

    task automatic do_op(input int r, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] ctl, input logic stall, input logic [1:0] clr);
        bit got;
        ob_iss = -1; ob_rsp = -1; ob_rv = 2'b00; ob_res = 4'd0;
        ob_c = 1'b0; ob_z = 1'b0; ob_e = 1'b0;
        alu_stall = stall;
        req_valid[r] = 1'b1;
        req_a[4*r +: 4] = a;
        req_b[4*r +: 4] = b;
        req_ctl[4*r +: 4] = ctl;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            #1;
            if (req_ready[r]) got = 1'b1;
            else @(negedge clk);
        end
        chk("op_accept", int'(got), 1);
        @(negedge clk);
        req_valid[r] = 1'b0;
        got = 1'b0;
        for (int k = 1; k <= 12 && !got; k++) begin
            #1;
            if (alu_valid_in && ob_iss < 0) begin
                ob_iss = k; ob_a = alu_a; ob_b = alu_b; ob_ctl = alu_ctl; ob_cin = alu_cin;
            end
            if (rsp_valid != 2'b00) begin
                ob_rsp = k; ob_rv = rsp_valid; ob_res = rsp_result;
                ob_c = rsp_carry; ob_z = rsp_zero; ob_e = rsp_err;
                flag_clr = clr;
                got = 1'b1;
            end
            @(negedge clk);
        end
        chk("op_rsp_seen", int'(got), 1);
        flag_clr = 2'b00;
        alu_stall = 1'b0;
        #1;
        ob_flag = flag;
    endtask

    typedef struct {
        int         r;
        logic [3:0] a, b, ctl;
        logic       stall;
        logic [1:0] clr;
        int         e_iss, e_rsp;
        logic [3:0] e_res;
        logic       e_c, e_z, e_err, e_cin;
        logic [1:0] e_flag;
    } vec_t;

    vec_t tbl[10];

    // Random-phase model state
    int         last_m, next_acc, iss_c, rsp_c, o_m;
    logic       err_m, pc, pz;
    logic [3:0] pa, pb, pctl, pres;
    logic [1:0] fm, eg, erv, drop;
    logic [4:0] fr;

    logic [1:0] g[4], rvq[4];
    int         gc[4];
    logic [3:0] rres[4];
    int         ng, nr;
    bit         got;

    initial begin
        //          r  a     b     ctl   st clr    iss rsp res   c  z  e  cin flag
        tbl[0] = '{0, 4'h9, 4'h8, 4'h3, 0, 2'b00,  1, 3,  4'h1, 1, 0, 0, 0, 2'b01};
        tbl[1] = '{0, 4'h1, 4'h1, 4'h4, 0, 2'b00,  1, 3,  4'h3, 0, 0, 0, 1, 2'b00};
        tbl[2] = '{1, 4'hF, 4'h1, 4'h3, 0, 2'b00,  1, 3,  4'h0, 1, 1, 0, 0, 2'b10};
        tbl[3] = '{0, 4'h9, 4'h8, 4'h3, 0, 2'b01,  1, 3,  4'h1, 1, 0, 0, 0, 2'b10};
        tbl[4] = '{1, 4'h0, 4'h0, 4'hE, 0, 2'b00, -1, 1,  4'h0, 0, 0, 1, 0, 2'b10};
        tbl[5] = '{0, 4'h2, 4'h3, 4'hF, 0, 2'b00, -1, 1,  4'h0, 0, 0, 1, 0, 2'b10};
        tbl[6] = '{1, 4'h0, 4'h0, 4'h4, 0, 2'b00,  1, 3,  4'h1, 0, 0, 0, 1, 2'b00};
        tbl[7] = '{0, 4'h0, 4'h7, 4'h0, 0, 2'b00,  1, 3,  4'h7, 0, 0, 0, 0, 2'b00};
        tbl[8] = '{1, 4'h5, 4'h5, 4'h3, 1, 2'b00,  1, 6,  4'h0, 0, 0, 1, 0, 2'b00};
        tbl[9] = '{0, 4'h4, 4'h4, 4'h3, 0, 2'b00,  1, 3,  4'h8, 0, 0, 0, 0, 2'b00};

        @(negedge clk);
        @(negedge clk);
        #1;
        rst_checks("init");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].ctl, tbl[i].stall, tbl[i].clr);
            chk($sformatf("v%0d_issue_at", i), ob_iss, tbl[i].e_iss);
            chk($sformatf("v%0d_rsp_at", i), ob_rsp, tbl[i].e_rsp);
            chk($sformatf("v%0d_rsp_valid", i), int'(ob_rv), (tbl[i].r == 1) ? 2 : 1);
            chk($sformatf("v%0d_err", i), int'(ob_e), int'(tbl[i].e_err));
            if (!tbl[i].e_err) begin
                chk($sformatf("v%0d_result", i), int'(ob_res), int'(tbl[i].e_res));
                chk($sformatf("v%0d_carry", i), int'(ob_c), int'(tbl[i].e_c));
                chk($sformatf("v%0d_zero", i), int'(ob_z), int'(tbl[i].e_z));
            end
            if (tbl[i].e_iss > 0) begin
                chk($sformatf("v%0d_alu_ops", i), int'({ob_a, ob_b, ob_ctl}),
                    int'({tbl[i].a, tbl[i].b, tbl[i].ctl}));
                chk($sformatf("v%0d_alu_cin", i), int'(ob_cin), int'(tbl[i].e_cin));
            end
            chk($sformatf("v%0d_flag", i), int'(ob_flag), int'(tbl[i].e_flag));
        end

        // Reset while an op is parked in WAIT
        do_op(1, 4'hF, 4'h1, 4'h3, 1'b0, 2'b00);
        chk("mr_pre_flag", int'(ob_flag), 2);
        alu_stall = 1'b1;
        req_valid[1] = 1'b1;
        req_ctl[7:4] = 4'h3;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            #1;
            if (req_ready[1]) got = 1'b1;
            else @(negedge clk);
        end
        chk("mr_accept", int'(got), 1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        rst_checks("midrst");
        @(negedge clk);
        reset = 1'b1;
        alu_stall = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("midrst_no_rsp", int'({rsp_valid, alu_valid_in}), 0);
            @(negedge clk);
        end

        // Both valid continuously: grants alternate starting with requester 0
        do_reset();
        req_b = {4'd10, 4'd5};
        req_ctl = 8'h00;
        req_valid = 2'b11;
        ng = 0; nr = 0;
        for (int k = 0; k < 30 && nr < 4; k++) begin
            #1;
            if (req_ready != 2'b00 && ng < 4) begin g[ng] = req_ready; gc[ng] = k; ng++; end
            if (rsp_valid != 2'b00 && nr < 4) begin rvq[nr] = rsp_valid; rres[nr] = rsp_result; nr++; end
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk("rr_grant_count", ng, 4);
        chk("rr_rsp_count", nr, 4);
        for (int i = 0; i < ng; i++) begin
            chk($sformatf("rr_grant%0d", i), int'(g[i]), (i % 2 == 0) ? 1 : 2);
            if (i > 0) chk($sformatf("rr_spacing%0d", i), gc[i] - gc[i-1], 4);
        end
        for (int i = 0; i < nr; i++) begin
            chk($sformatf("rr_rsp_owner%0d", i), int'(rvq[i]), (i % 2 == 0) ? 1 : 2);
            chk($sformatf("rr_rsp_result%0d", i), int'(rres[i]), (i % 2 == 0) ? 5 : 10);
        end

        // Randomized traffic against a transaction-level schedule model
        do_reset();
        last_m = 1; next_acc = 0; iss_c = -1; rsp_c = -1; o_m = 0;
        fm = 2'b00; err_m = 1'b0; drop = 2'b00;
        pa = 0; pb = 0; pctl = 0; pres = 0; pc = 0; pz = 0;
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (drop[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    req_a[4*i +: 4] = 4'($urandom);
                    req_b[4*i +: 4] = 4'($urandom);
                    req_ctl[4*i +: 4] = 4'($urandom_range(0, 15));
                end
            end
            drop = 2'b00;
            flag_clr = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            alu_stall = ($urandom_range(0, 7) == 0);
            #1;
            eg = 2'b00;
            if (n >= next_acc) begin
                if (req_valid == 2'b11) eg = (last_m == 1) ? 2'b01 : 2'b10;
                else                    eg = req_valid;
            end
            chk("rand_ready", int'(req_ready), int'(eg));
            chk("rand_issue", int'(alu_valid_in), int'(n == iss_c));
            if (n == iss_c) begin
                chk("rand_alu_ops", int'({alu_a, alu_b, alu_ctl}), int'({pa, pb, pctl}));
                chk("rand_alu_cin", int'(alu_cin), int'(fm[o_m]));
                if (alu_stall) begin
                    err_m = 1'b1;
                    rsp_c = n + 1 + TO;
                end else begin
                    fr = alu_fn(pa, pb, pctl, fm[o_m]);
                    pres = fr[3:0]; pc = fr[4]; pz = (fr[3:0] == 4'd0);
                    err_m = 1'b0;
                    rsp_c = n + 2;
                end
                next_acc = rsp_c + 1;
            end
            erv = (n == rsp_c) ? (o_m == 1 ? 2'b10 : 2'b01) : 2'b00;
            chk("rand_rsp_valid", int'(rsp_valid), int'(erv));
            if (n == rsp_c) begin
                chk("rand_rsp_err", int'(rsp_err), int'(err_m));
                if (!err_m) chk("rand_rsp_data", int'({rsp_result, rsp_carry, rsp_zero}),
                                int'({pres, pc, pz}));
            end
            chk("rand_flag", int'(flag), int'(fm));
            for (int i = 0; i < 2; i++) begin
                if (flag_clr[i]) fm[i] = 1'b0;
                else if (n == rsp_c && !err_m && o_m == i) fm[i] = pc;
            end
            if (eg != 2'b00) begin
                o_m = eg[1] ? 1 : 0;
                last_m = o_m;
                drop[o_m] = 1'b1;
                pa = req_a[4*o_m +: 4];
                pb = req_b[4*o_m +: 4];
                pctl = req_ctl[4*o_m +: 4];
                if (pctl >= 4'hE) begin
                    err_m = 1'b1;
                    rsp_c = n + 1;
                    next_acc = n + 2;
                end else begin
                    iss_c = n + 1;
                    next_acc = 1 << 30;
                end
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        flag_clr = 2'b00;
        alu_stall = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin front end that shares one registered 4-bit ALU. Each requester has its own carry-flag register, and that flag is driven as the ALU carry input for the requester's ops. The block accepts requests with a valid/ready handshake and issues one op at a time to the ALU. It captures the ALU's one-cycle-latency result and returns a per-requester response pulse. Invalid opcodes and stalled ALU responses are reported as errors instead of hanging.

## Interface
Parameters:
- TIMEOUT, 4, cycles to wait in WAIT for alu_valid_out before returning an error (≥2).

Ports. Packed per-requester fields: requester i occupies bit i, or bits [4i+3:4i] for 4-bit fields.
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  2  request valid per requester
- req_ready  out  2  request accepted this cycle (one-hot or zero)
- req_a  in  8  operand A per requester
- req_b  in  8  operand B per requester
- req_ctl  in  8  opcode per requester (opcode_e encoding)
- flag_clr  in  2  synchronous clear of requester carry flag
- rsp_valid  out  2  one-cycle response pulse per requester (no backpressure)
- rsp_result  out  4  result of completed op
- rsp_carry  out  1  carry of completed op
- rsp_zero  out  1  alu_zero forwarded unmodified
- rsp_err  out  1  qualifies rsp_valid: invalid opcode or timeout
- flag  out  2  current carry-flag registers
- alu_valid_in  out  1  issue strobe to ALU
- alu_a, alu_b, alu_ctl  out  4 each  operands and opcode to ALU
- alu_cin  out  1  carry-flag of the current owner
- alu_valid_out  in  1  ALU result valid
- alu_result  in  4  ALU result
- alu_carry, alu_zero  in  1 each  ALU flags

## Operation
- FSM states:
  - IDLE: grant requester, go ISSUE or ERR.
  - ISSUE: alu_valid_in=1 for exactly one cycle, go WAIT.
  - WAIT: count cycles; on alu_valid_out go RESP; at TIMEOUT go ERR.
  - RESP: pulse rsp_valid[owner] with captured data, go IDLE.
  - ERR: pulse rsp_valid[owner] with rsp_err=1, go IDLE.
- Arbitration:
  - Performed only in IDLE; req_ready is combinational from req_valid and the last-grant pointer.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted.
  - The pointer updates on each handshake.
- On handshake, latch a, b, ctl and the owner index.
- ctl values 4'hE and 4'hF are invalid: no ALU issue, go directly to ERR.
- While not in ISSUE, alu_a, alu_b, alu_ctl hold the latched values and alu_valid_in=0. alu_cin=flag[owner] always.
- On RESP, flag[owner] ← captured alu_carry. ERR leaves flags unchanged.
- flag_clr[i] clears flag[i] at the clock edge; clear wins over a coincident update.
- rsp_result, rsp_carry, rsp_zero, rsp_err hold their last values between pulses. They are don't-care unless rsp_valid.
- alu_valid_out seen outside WAIT is ignored.

## Timing
- Reset (async assert, sync deassert by system):
  - state=IDLE, last-grant pointer=1 (requester 0 wins first tie).
  - All outputs 0: req_ready, rsp_valid, rsp_*, flag, alu_*.
- Valid op accepted at cycle T:
  - alu_valid_in high in T+1.
  - ALU result returns in T+2.
  - rsp_valid pulses in T+3.
  - Next accept is possible at T+4 (IDLE). Throughput is one op per 4 cycles.
- Invalid op accepted at T: rsp_valid with rsp_err=1 in T+1.
- Timeout: rsp_err pulse TIMEOUT+1 cycles after the ISSUE cycle. Counter clears on entering WAIT.
- Reset mid-operation:
  - The outstanding op is dropped and no response is issued.
  - Flags clear.
- The requester must hold req_valid and its fields stable until req_ready.

## Structure
- Shared package alu_pkg:
  - opcode_e enum (SEL…ROTATE_R, invalid_1, invalid_2).
  - arb_state_e enum (IDLE, ISSUE, WAIT, RESP, ERR).
  - Helper function is_valid_op(ctl).
- Sub-module rr_arbiter2: 2-way round-robin grant with a pointer that updates on an accept input.
- Everything else (FSM, operand latches, timeout counter, flags) lives in alu_arbiter.

## Test plan
- Req0 ADD a=9 b=8 with ALU model attached:
  - alu_valid_in at T+1 with a=9, b=8, ctl=3, cin=0.
  - rsp_valid=2'b01 at T+3 with result=1, carry=1, err=0.
  - flag=2'b01.
- Follow-up req0 ADD_c a=1 b=1: alu_cin=1, result=3, carry=0, flag[0]→0. Req1 flag unaffected throughout.
- Both requesters valid continuously with SEL b=i: grants alternate 0,1,0,1 starting with 0, each response to the matching rsp_valid bit, 4-cycle spacing.
- Req1 ctl=4'hE at T: no alu_valid_in; rsp_valid=2'b10, rsp_err=1 at T+1; flags unchanged.
- ALU stub never asserts alu_valid_out, TIMEOUT=4: rsp_err pulse 5 cycles after ISSUE, then block accepts the next request.
- Assert reset during WAIT: no rsp_valid, all outputs 0, flags cleared. After release, req0 is granted first.
- flag_clr[0] in the same cycle as a RESP with carry=1 for requester 0: flag[0]=0.
